// File: rtl/ubin_dec_bi.sv
// ubin_dec_bi: bipolar unary-to-binary decoder.
// Counts 1s over a window of 2**INWD enabled cycles and reports the count as an
// offset-binary value (2**(INWD-1) == bipolar 0), saturating an all-ones window
// to the largest code.
// Optional feature macro: DEC_SIGNED_OUT_EN -- when defined, oC is presented as
// two's complement (offset-binary MSB inverted). oSat meaning is unchanged.
module ubin_dec_bi #(
  parameter int INWD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
  input  logic            iEn,
  input  logic            iA,
  output logic [INWD-1:0] oC,
  output logic            oValid,
  input  logic            oAck,
  output logic            oSat,
  output logic            oOvf,
  output logic            oBusy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Last cycle index of a window (N-1) and an INWD-wide increment.
  localparam logic [INWD-1:0] LAST_CYC = {INWD{1'b1}};
  localparam logic [INWD-1:0] CYC_ONE  = {{(INWD-1){1'b0}}, 1'b1};

  state_t          state;
  logic            cont_q;
  logic [INWD-1:0] cyc;
  logic [INWD:0]   ones;

  logic [INWD:0]   sum;
  logic            win_end;
  logic            sum_sat;
  logic [INWD-1:0] result;

  // Map a window sum (0..N) onto the output code; N saturates to N-1.
  function automatic logic [INWD-1:0] encode(input logic [INWD:0] s);
    logic [INWD-1:0] v;
    if (s[INWD]) begin
      v = {INWD{1'b1}};
    end else begin
      v = s[INWD-1:0];
    end
`ifdef DEC_SIGNED_OUT_EN
    v[INWD-1] = ~v[INWD-1];
`else
    v[INWD-1] = v[INWD-1];
`endif
    return v;
  endfunction

  // Final sum including the current bit and detection of a completing window;
  // a start on the same edge aborts the window, so it suppresses the result.
  always_comb begin
    sum     = ones + {{INWD{1'b0}}, iA};
    win_end = 1'b0;
    if ((state == COUNT) && iEn && !start && (cyc == LAST_CYC)) begin
      win_end = 1'b1;
    end else begin
      win_end = 1'b0;
    end
    sum_sat = sum[INWD];
    result  = encode(sum);
  end

  // Window state machine, counters and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cont_q <= 1'b0;
      cyc    <= {INWD{1'b0}};
      ones   <= {(INWD+1){1'b0}};
      oC     <= {INWD{1'b0}};
      oValid <= 1'b0;
      oSat   <= 1'b0;
      oOvf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COUNT;
            cont_q <= cont;
            cyc    <= {INWD{1'b0}};
            ones   <= {(INWD+1){1'b0}};
          end else begin
            state <= IDLE;
          end
        end
        COUNT: begin
          if (start) begin
            // Abort the running window and restart with the new mode.
            cont_q <= cont;
            cyc    <= {INWD{1'b0}};
            ones   <= {(INWD+1){1'b0}};
          end else if (win_end) begin
            cyc  <= {INWD{1'b0}};
            ones <= {(INWD+1){1'b0}};
            if (cont_q) begin
              state <= COUNT;
            end else begin
              state <= IDLE;
            end
          end else if (iEn) begin
            cyc  <= cyc + CYC_ONE;
            ones <= sum;
          end else begin
            cyc  <= cyc;
            ones <= ones;
          end
        end
        default: begin
          state <= IDLE;
          cyc   <= {INWD{1'b0}};
          ones  <= {(INWD+1){1'b0}};
        end
      endcase

      // A new result always loads; it only counts as an overwrite when the
      // previous result is still pending and not being accepted this edge.
      if (win_end) begin
        oC     <= result;
        oSat   <= sum_sat;
        oValid <= 1'b1;
        if (oValid && !oAck) begin
          oOvf <= 1'b1;
        end else begin
          oOvf <= oOvf;
        end
      end else if (oValid && oAck) begin
        oValid <= 1'b0;
      end else begin
        oValid <= oValid;
      end
    end
  end

  // The state register is the busy flag.
  assign oBusy = (state == COUNT);

endmodule
